// File: rtl/counter_pkg.sv
// Shared definitions for the parametrised counter: mode encodings and the
// segment-count helper used by the interface, datapath and register stage.
package counter_pkg;

   // Counter operating modes as carried on MODO.
   typedef enum logic [1:0] {
      MODE_UP   = 2'b00,
      MODE_DOWN = 2'b01,
      MODE_STEP = 2'b10,
      MODE_LOAD = 2'b11
   } mode_e;

   // Number of SEG_W-wide segments reported on SEG_RCO.
   function automatic int unsigned calc_nseg(input int unsigned width,
                                             input int unsigned seg_w);
      return width / seg_w;
   endfunction

endpackage : counter_pkg

// File: rtl/counter_param_if.sv
// Control/data bundle between a counter user and counter_param. The user
// (master) drives enable, mode and load data; the counter (slave) returns
// the count, the wrap flags and the lookahead terminal-count.
interface counter_param_if
   import counter_pkg::*;
#(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned SEG_W = 4
);
   localparam int unsigned NSEG = calc_nseg(WIDTH, SEG_W);

   logic             ENB;
   logic [1:0]       MODO;
   logic [WIDTH-1:0] D;
   logic [WIDTH-1:0] Q;
   logic             RCO;
   logic [NSEG-1:0]  SEG_RCO;
   logic             TC;

   modport master (
      output ENB, MODO, D,
      input  Q, RCO, SEG_RCO, TC
   );

   modport slave (
      input  ENB, MODO, D,
      output Q, RCO, SEG_RCO, TC
   );

endinterface : counter_param_if

// File: rtl/counter_next_val.sv
// Combinational datapath of the counter: from the current value, mode and
// load data it produces the next value, the per-segment wrap vector and the
// raw (ungated) full-width wrap used for TC.
module counter_next_val
   import counter_pkg::*;
#(
   parameter int unsigned WIDTH    = 16,
   parameter int unsigned SEG_W    = 4,
   parameter int unsigned DEC_STEP = 3,
   localparam int unsigned NSEG    = calc_nseg(WIDTH, SEG_W)
) (
   input  logic [WIDTH-1:0] q,
   input  logic [1:0]       modo,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q_next,
   output logic [NSEG-1:0]  seg_wrap,
   output logic             tc_raw
);

   // Step amount, truncated to the counter width, with a zero carry bit.
   localparam logic [WIDTH-1:0] STEP_T = WIDTH'(DEC_STEP);
   localparam logic [WIDTH:0]   STEP_X = {1'b0, STEP_T};

   logic [WIDTH:0] ext;

   // Full-width arithmetic in WIDTH+1 bits; the top bit is the carry/borrow.
   always_comb begin
      ext = {1'b0, q};
      unique case (mode_e'(modo))
         MODE_UP:   ext = {1'b0, q} + (WIDTH+1)'(1);
         MODE_DOWN: ext = {1'b0, q} - (WIDTH+1)'(1);
         MODE_STEP: ext = {1'b0, q} - STEP_X;
         MODE_LOAD: ext = {1'b0, d};
         default:   ext = {1'b0, q};
      endcase
   end

   assign q_next = ext[WIDTH-1:0];
   assign tc_raw = ext[WIDTH];

   for (genvar k = 0; k < NSEG; k++) begin : g_seg
      localparam int unsigned LW = (k + 1) * SEG_W;

      logic [LW-1:0]  lk;
      logic [WIDTH:0] lk_ext;
      logic [WIDTH:0] lk_dec;
      logic           wrap_k;

      assign lk     = q[LW-1:0];
      assign lk_ext = (WIDTH+1)'(lk);
      assign lk_dec = lk_ext - STEP_X;

      // Wrap of the low LW bits: all-ones going up, zero going down, and
      // a borrow when the low slice is smaller than the step.
      always_comb begin
         wrap_k = 1'b0;
         unique case (mode_e'(modo))
            MODE_UP:   wrap_k = (lk == '1);
            MODE_DOWN: wrap_k = (lk == '0);
            MODE_STEP: wrap_k = lk_dec[WIDTH];
            MODE_LOAD: wrap_k = 1'b0;
            default:   wrap_k = 1'b0;
         endcase
      end

      assign seg_wrap[k] = wrap_k;
   end

endmodule : counter_next_val

// File: rtl/counter_param.sv
// Parametrised synchronous up/down/step/load counter. All state updates on
// the single CLK edge; this level holds only the registers, the async reset
// and the enable gating around the counter_next_val datapath.
module counter_param
   import counter_pkg::*;
#(
   parameter int unsigned WIDTH    = 16,
   parameter int unsigned SEG_W    = 4,
   parameter int unsigned DEC_STEP = 3
) (
   input  logic                  CLK,
   input  logic                  RST_N,
   counter_param_if.slave        bus
);

   localparam int unsigned NSEG = calc_nseg(WIDTH, SEG_W);

   if ((WIDTH % SEG_W) != 0) begin : g_bad_seg_w
      $error("counter_param: WIDTH must be a multiple of SEG_W");
   end
   if (DEC_STEP == 0) begin : g_bad_dec_step
      $error("counter_param: DEC_STEP must be non-zero");
   end

   logic [WIDTH-1:0] q_q, q_d;
   logic             rco_q, rco_d;
   logic [NSEG-1:0]  seg_rco_q, seg_rco_d;

   logic [WIDTH-1:0] q_next;
   logic [NSEG-1:0]  seg_wrap;
   logic             tc_raw;

   counter_next_val #(
      .WIDTH    (WIDTH),
      .SEG_W    (SEG_W),
      .DEC_STEP (DEC_STEP)
   ) u_next_val (
      .q        (q_q),
      .modo     (bus.MODO),
      .d        (bus.D),
      .q_next   (q_next),
      .seg_wrap (seg_wrap),
      .tc_raw   (tc_raw)
   );

   // Enable gating: hold the count and clear the wrap pulses when disabled.
   always_comb begin
      q_d       = q_q;
      seg_rco_d = '0;
      if (bus.ENB) begin
         q_d       = q_next;
         seg_rco_d = seg_wrap;
      end
      rco_d = seg_rco_d[NSEG-1];
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         q_q       <= '0;
         rco_q     <= 1'b0;
         seg_rco_q <= '0;
      end else begin
         q_q       <= q_d;
         rco_q     <= rco_d;
         seg_rco_q <= seg_rco_d;
      end
   end

   assign bus.Q       = q_q;
   assign bus.RCO     = rco_q;
   assign bus.SEG_RCO = seg_rco_q;
   assign bus.TC      = bus.ENB & tc_raw;

endmodule : counter_param

// File: tb/tb_counter_param.sv
// Directed bench for counter_param (WIDTH=16, SEG_W=4, DEC_STEP=3): a table
// of single-edge vectors with hand-computed results, plus hand-written
// sequences for asynchronous reset assertion, release and reset-wins.
module tb_counter_param;

   logic clk;
   logic rst_n;

   int checks;
   int failures;

   counter_param_if #(.WIDTH(16), .SEG_W(4)) bus ();

   counter_param #(
      .WIDTH    (16),
      .SEG_W    (4),
      .DEC_STEP (3)
   ) dut (
      .CLK   (clk),
      .RST_N (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       nm;
      logic        enb;
      logic [1:0]  modo;
      logic [15:0] d;
      logic        tc;    // TC expected before the edge
      logic [15:0] q;     // results after the edge
      logic        rco;
      logic [3:0]  seg;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic chk_outs(input string nm, input logic [15:0] q, input logic rco, input logic [3:0] seg);
      chk({nm, ".Q"},       32'(bus.Q),       32'(q));
      chk({nm, ".RCO"},     32'(bus.RCO),     32'(rco));
      chk({nm, ".SEG_RCO"}, 32'(bus.SEG_RCO), 32'(seg));
   endtask

   task automatic drive(input logic enb, input logic [1:0] modo, input logic [15:0] d);
      @(negedge clk);
      bus.ENB  = enb;
      bus.MODO = modo;
      bus.D    = d;
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst_n    = 1'b0;
      bus.ENB  = 1'b0;
      bus.MODO = 2'b00;
      bus.D    = 16'h0000;

      // name, enb, modo, d, tc_before, q, rco, seg
      vecs.push_back('{"ld_fffe", 1'b1, 2'b11, 16'hFFFE, 1'b0, 16'hFFFE, 1'b0, 4'b0000});
      vecs.push_back('{"up_fffe", 1'b1, 2'b00, 16'h0000, 1'b0, 16'hFFFF, 1'b0, 4'b0000});
      vecs.push_back('{"up_ffff", 1'b1, 2'b00, 16'h0000, 1'b1, 16'h0000, 1'b1, 4'b1111});
      vecs.push_back('{"up_0000", 1'b1, 2'b00, 16'h0000, 1'b0, 16'h0001, 1'b0, 4'b0000});
      vecs.push_back('{"ld_00ff", 1'b1, 2'b11, 16'h00FF, 1'b0, 16'h00FF, 1'b0, 4'b0000});
      vecs.push_back('{"up_00ff", 1'b1, 2'b00, 16'h0000, 1'b0, 16'h0100, 1'b0, 4'b0011});
      vecs.push_back('{"ld_0000", 1'b1, 2'b11, 16'h0000, 1'b0, 16'h0000, 1'b0, 4'b0000});
      vecs.push_back('{"dn_0000", 1'b1, 2'b01, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 4'b1111});
      vecs.push_back('{"dn_ffff", 1'b1, 2'b01, 16'h0000, 1'b0, 16'hFFFE, 1'b0, 4'b0000});
      vecs.push_back('{"ld_0002", 1'b1, 2'b11, 16'h0002, 1'b0, 16'h0002, 1'b0, 4'b0000});
      vecs.push_back('{"st_0002", 1'b1, 2'b10, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 4'b1111});
      vecs.push_back('{"ld_0013", 1'b1, 2'b11, 16'h0013, 1'b0, 16'h0013, 1'b0, 4'b0000});
      vecs.push_back('{"st_0013", 1'b1, 2'b10, 16'h0000, 1'b0, 16'h0010, 1'b0, 4'b0000});
      vecs.push_back('{"st_0010", 1'b1, 2'b10, 16'h0000, 1'b0, 16'h000D, 1'b0, 4'b0001});
      vecs.push_back('{"ld_0012", 1'b1, 2'b11, 16'h0012, 1'b0, 16'h0012, 1'b0, 4'b0000});
      vecs.push_back('{"st_0012", 1'b1, 2'b10, 16'h0000, 1'b0, 16'h000F, 1'b0, 4'b0001});
      vecs.push_back('{"ld_0010", 1'b1, 2'b11, 16'h0010, 1'b0, 16'h0010, 1'b0, 4'b0000});
      vecs.push_back('{"hold_00", 1'b0, 2'b00, 16'hAAAA, 1'b0, 16'h0010, 1'b0, 4'b0000});
      vecs.push_back('{"hold_01", 1'b0, 2'b01, 16'hAAAA, 1'b0, 16'h0010, 1'b0, 4'b0000});
      vecs.push_back('{"hold_10", 1'b0, 2'b10, 16'hAAAA, 1'b0, 16'h0010, 1'b0, 4'b0000});
      vecs.push_back('{"hold_11", 1'b0, 2'b11, 16'hAAAA, 1'b0, 16'h0010, 1'b0, 4'b0000});
      vecs.push_back('{"hold_00b",1'b0, 2'b00, 16'hAAAA, 1'b0, 16'h0010, 1'b0, 4'b0000});
      vecs.push_back('{"ld_aaaa", 1'b1, 2'b11, 16'hAAAA, 1'b0, 16'hAAAA, 1'b0, 4'b0000});
      vecs.push_back('{"ld_ffff", 1'b1, 2'b11, 16'hFFFF, 1'b0, 16'hFFFF, 1'b0, 4'b0000});
      vecs.push_back('{"dis_ffff",1'b0, 2'b00, 16'h0000, 1'b0, 16'hFFFF, 1'b0, 4'b0000});
      vecs.push_back('{"up_wrap", 1'b1, 2'b00, 16'h0000, 1'b1, 16'h0000, 1'b1, 4'b1111});
      vecs.push_back('{"dis_post",1'b0, 2'b00, 16'h0000, 1'b0, 16'h0000, 1'b0, 4'b0000});

      // Reset state with no clock edge seen yet.
      #2;
      chk_outs("reset_init", 16'h0000, 1'b0, 4'b0000);
      chk("reset_init.TC", 32'(bus.TC), 32'd0);

      @(negedge clk);
      rst_n = 1'b1;

      // Table-driven single-edge vectors.
      foreach (vecs[i]) begin
         drive(vecs[i].enb, vecs[i].modo, vecs[i].d);
         #1;
         chk({vecs[i].nm, ".TC"}, 32'(bus.TC), 32'(vecs[i].tc));
         @(posedge clk);
         #1;
         chk_outs(vecs[i].nm, vecs[i].q, vecs[i].rco, vecs[i].seg);
      end

      // Asynchronous reset between edges after a load.
      drive(1'b1, 2'b11, 16'h1234);
      @(posedge clk);
      #1;
      chk_outs("ld_1234", 16'h1234, 1'b0, 4'b0000);
      #2;
      rst_n = 1'b0;
      #1;
      chk_outs("async_rst_ld", 16'h0000, 1'b0, 4'b0000);

      // Asynchronous reset clears a live wrap pulse without an edge.
      drive(1'b1, 2'b11, 16'hFFFF);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk_outs("ld_ffff_b", 16'hFFFF, 1'b0, 4'b0000);
      drive(1'b1, 2'b00, 16'h0000);
      @(posedge clk);
      #1;
      chk_outs("wrap_b", 16'h0000, 1'b1, 4'b1111);
      #2;
      rst_n = 1'b0;
      #1;
      chk_outs("async_rst_rco", 16'h0000, 1'b0, 4'b0000);

      // Reset held across an enabled edge: reset wins.
      drive(1'b1, 2'b01, 16'h0000);
      @(posedge clk);
      #1;
      chk_outs("rst_wins", 16'h0000, 1'b0, 4'b0000);

      // Release between edges; first enabled edge does the first update.
      drive(1'b1, 2'b00, 16'h0000);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk_outs("rel_first", 16'h0001, 1'b0, 4'b0000);
      drive(1'b1, 2'b10, 16'h0000);
      #1;
      chk("rel_step.TC", 32'(bus.TC), 32'd1);
      @(posedge clk);
      #1;
      chk_outs("rel_step", 16'hFFFE, 1'b1, 4'b1111);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_counter_param
